// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the execute-stage ALU:
//   alu_ctrl_e    4-bit ALU control code produced by decode
//   ALUOP_*       main-decoder ALUOp encodings
//   FUNCT7_*      funct7 groups for R-type decode
//   exec_state_e  execute-unit FSM states
//   base_ctrl()   funct3 -> control code for the base integer set
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_MUL  = 4'b1010,
    ALU_RSVD = 4'b1011,
    ALU_DIV  = 4'b1100,
    ALU_DIVU = 4'b1101,
    ALU_REM  = 4'b1110,
    ALU_REMU = 4'b1111
  } alu_ctrl_e;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } exec_state_e;

  // Shared by R-type (funct7 = base) and I-type decode.
  function automatic alu_ctrl_e base_ctrl(input logic [2:0] f3);
    alu_ctrl_e c;
    case (f3)
      3'b000:  c = ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// -----------------------------------------------------------------------------
// alu_muldiv_iter
// Iterative multiply / divide datapath, one step per clock for XLEN clocks.
//   MUL            : shift-add, low XLEN bits of the product
//   DIV/DIVU/REM/REMU : restoring division on magnitudes, sign fix-up at end
// Divide by zero gives quotient all-ones and remainder = dividend; signed
// MIN / -1 falls out of the magnitude algorithm as quotient MIN, remainder 0.
// Only compiled when ALU_MULDIV_EN is defined.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load operands and begin (ignored while busy)
//   op           ALU_MUL / ALU_DIV / ALU_DIVU / ALU_REM / ALU_REMU
//   a, b         operands (multiplicand/multiplier or dividend/divisor)
//   done         high during the final step; result is valid in that cycle
//   result       fixed-up result of the final step (combinational)
// -----------------------------------------------------------------------------
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  alu_ctrl_e       op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   count;
  // Working registers are shared between the two algorithms:
  //   MUL: x = shifting multiplicand, y = shifting multiplier, acc = product
  //   DIV: x = dividend shifting out / quotient shifting in, y = divisor,
  //        acc = partial remainder
  logic [XLEN-1:0] x, y, acc, a_raw;
  logic            is_mul, want_rem, neg_q, neg_r, div_zero;

  logic            is_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   r_shift, diff;
  logic            fits;
  logic [XLEN-1:0] x_nxt, y_nxt, acc_nxt, quo_fix, rem_fix;

  always_comb begin
    is_sgn = (op == ALU_DIV) || (op == ALU_REM);
    a_neg  = is_sgn && a[XLEN-1];
    b_neg  = is_sgn && b[XLEN-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
  end

  always_comb begin
    r_shift = {acc, x[XLEN-1]};
    diff    = r_shift - {1'b0, y};
    fits    = !diff[XLEN];
    if (is_mul) begin
      acc_nxt = acc + (y[0] ? x : '0);
      x_nxt   = x << 1;
      y_nxt   = y >> 1;
    end else begin
      // Remainder is always below the divisor, so it fits in XLEN bits.
      acc_nxt = fits ? diff[XLEN-1:0] : r_shift[XLEN-1:0];
      x_nxt   = {x[XLEN-2:0], fits};
      y_nxt   = y;
    end
    quo_fix = neg_q ? -x_nxt : x_nxt;
    rem_fix = neg_r ? -acc_nxt : acc_nxt;
    if (is_mul)        result = acc_nxt;
    else if (want_rem) result = div_zero ? a_raw : rem_fix;
    else               result = div_zero ? '1 : quo_fix;
  end

  assign done = (count == CW'(1));

  // NOTE: only the step counter needs reset; the datapath registers are always
  // reloaded by start before they are used, so they sit in a reset-free block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               count <= '0;
    else if (start)           count <= CW'(XLEN);
    else if (count != '0)     count <= count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (start) begin
      is_mul   <= (op == ALU_MUL);
      want_rem <= (op == ALU_REM) || (op == ALU_REMU);
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div_zero <= (b == '0);
      a_raw    <= a;
      x        <= (op == ALU_MUL) ? a : a_mag;
      y        <= (op == ALU_MUL) ? b : b_mag;
      acc      <= '0;
    end else if (count != '0) begin
      x   <= x_nxt;
      y   <= y_nxt;
      acc <= acc_nxt;
    end
  end

endmodule
`endif

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage unit: ALU-control decode, single-cycle integer ALU and, when
// ALU_MULDIV_EN is defined, an iterative multiply/divide path. Valid/ready
// handshake on input and output; registered result/zero/illegal held stable
// while the output is stalled. With ALU_MULDIV_EN undefined, funct7=0000001
// decodes illegal and every op completes in one cycle.
//
// Parameters:
//   XLEN   datapath width (32 or 64)
//   SHW    shift-amount width, derived from XLEN
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (transfer when both high)
//   instruction     funct7 = [31:25], funct3 = [14:12], [30] selects SRAI
//   alu_op          00 load/store, 01 branch, 10 R-type, 11 I-type
//   op_a, op_b      operands
//   out_valid/out_ready output handshake
//   result, zero    registered result and result == 0
//   illegal         op did not decode (qualified by out_valid)
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [1:0]      alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  exec_state_e     state;
  alu_ctrl_e       ctrl;
  logic            dec_illegal;
  logic            is_m;
  logic            accept;
  logic [6:0]      f7;
  logic [2:0]      f3;
  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] alu_res, single_res;
  logic            unused_instr;

  assign f7 = instruction[31:25];
  assign f3 = instruction[14:12];
  assign unused_instr = ^{instruction[24:15], instruction[11:0]};

  // ---------------------------------------------------------------- decode
  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis would infer latches.
  always_comb begin
    ctrl        = ALU_ADD;
    dec_illegal = 1'b0;
    case (alu_op)
      ALUOP_MEM:    ctrl = ALU_ADD;
      ALUOP_BRANCH: ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        if (f7 == FUNCT7_BASE) begin
          ctrl = base_ctrl(f3);
        end else if (f7 == FUNCT7_ALT && f3 == 3'b000) begin
          ctrl = ALU_SUB;
        end else if (f7 == FUNCT7_ALT && f3 == 3'b101) begin
          ctrl = ALU_SRA;
`ifdef ALU_MULDIV_EN
        end else if (f7 == FUNCT7_MULDIV) begin
          case (f3)
            3'b000:  ctrl = ALU_MUL;
            3'b100:  ctrl = ALU_DIV;
            3'b101:  ctrl = ALU_DIVU;
            3'b110:  ctrl = ALU_REM;
            3'b111:  ctrl = ALU_REMU;
            default: dec_illegal = 1'b1;
          endcase
`endif
        end else begin
          dec_illegal = 1'b1;
        end
      end
      ALUOP_ITYPE: begin
        // Immediate shifts carry the arithmetic flag in instruction[30].
        ctrl = base_ctrl(f3);
        if (f3 == 3'b101 && instruction[30]) ctrl = ALU_SRA;
      end
    endcase
  end

`ifdef ALU_MULDIV_EN
  assign is_m = !dec_illegal &&
                (ctrl inside {ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});
`else
  assign is_m = 1'b0;
`endif

  // ------------------------------------------------------ single-cycle ALU
  assign sh = op_b[SHW-1:0];

  always_comb begin
    case (ctrl)
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLL:  alu_res = op_a << sh;
      ALU_SRL:  alu_res = op_a >> sh;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> sh);
      ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_res = XLEN'(op_a < op_b);
      default:  alu_res = '0;
    endcase
  end

  assign single_res = dec_illegal ? '0 : alu_res;

  // ------------------------------------------------------------ handshake
  assign in_ready = (state == S_IDLE) || (state == S_DONE && out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_MULDIV_EN
  logic            md_done;
  logic [XLEN-1:0] md_result;

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && is_m),
    .op     (ctrl),
    .a      (op_a),
    .b      (op_b),
    .done   (md_done),
    .result (md_result)
  );
`endif

  // ------------------------------------------------------------------- FSM
  // NOTE: non-blocking assignments let a later assignment in the same branch
  // override an earlier one: a back-to-back accept in DONE wins over the
  // default return to IDLE written just above it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
          if (accept) begin
            if (is_m) begin
              state     <= S_RUN;
              out_valid <= 1'b0;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= single_res;
              zero      <= (single_res == '0);
              illegal   <= dec_illegal;
            end
          end
        end
`ifdef ALU_MULDIV_EN
        S_RUN: begin
          if (md_done) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= md_result;
            zero      <= (md_result == '0);
            illegal   <= 1'b0;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed self-checking bench for alu_exec_unit (XLEN = 64). Expected results
// are queued when an op is issued and popped when out_valid is observed.
// Expectations for M ops follow ALU_MULDIV_EN: real results with latency
// XLEN+1 when defined, illegal/zero with latency 1 otherwise.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam int XLEN = 64;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int LM = MD ? XLEN + 1 : 1;

  logic            clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic            zero, illegal;
  logic [31:0]     instruction;
  logic [1:0]      alu_op;
  logic [XLEN-1:0] op_a, op_b, result;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .alu_op      (alu_op),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] res;
    logic            ill;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = '1;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 10'h000, f3, 5'h00, 7'b0110011};
  endfunction

  function automatic logic [XLEN-1:0] md(input logic [XLEN-1:0] v);
    return MD ? v : '0;
  endfunction

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pops the next expectation and compares it with the current outputs.
  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = '{res: 'x, ill: 1'bx};
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " result"}, result, e.res);
    check({tag, " zero"}, zero, (e.res == '0));
    check({tag, " illegal"}, illegal, e.ill);
  endtask

  // Issues one op, scrambles the inputs after accept, then measures latency
  // in cycles to out_valid and compares the output against the scoreboard.
  task automatic issue(input string tag, input logic [1:0] aop,
                       input logic [31:0] ins, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] er,
                       input logic ei, input int lat);
    int n;
    exp_q.push_back('{res: er, ill: ei});
    @(posedge clk); #1;
    in_valid = 1'b1; alu_op = aop; instruction = ins; op_a = a; op_b = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    @(posedge clk); #1;
    in_valid    = 1'b0;
    instruction = $urandom();
    op_a        = {$urandom(), $urandom()};
    op_b        = {$urandom(), $urandom()};
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    check({tag, " latency"}, n, lat);
    compare_out(tag);
  endtask

  initial begin
    int hits;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; instruction = '0; op_a = '0; op_b = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst result", result, 0);
    check("rst zero", zero, 0);
    check("rst illegal", illegal, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst in_ready", in_ready, 1);

    // Single-cycle ops
    issue("sub_r",  2'b10, mk(7'b0100000, 3'b000), 5, 7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1);
    issue("srai",   2'b11, mk(7'b0100000, 3'b101), MIN, 4, 64'hF800_0000_0000_0000, 0, 1);
    issue("srli",   2'b11, mk(7'b0000000, 3'b101), MIN, 4, 64'h0800_0000_0000_0000, 0, 1);
    issue("add_ls", 2'b00, 32'h5550_0013, 10, -64'sd10, 0, 0, 1);
    issue("sub_br", 2'b01, 32'h0000_0063, 64'h1234, 64'h1234, 0, 0, 1);
    issue("addi",   2'b11, 32'h5550_0013, 7, -64'sd3, 4, 0, 1);
    issue("slt",    2'b10, mk(7'b0000000, 3'b010), ONES, 1, 1, 0, 1);
    issue("sltu",   2'b10, mk(7'b0000000, 3'b011), ONES, 1, 0, 0, 1);
    issue("sll",    2'b10, mk(7'b0000000, 3'b001), 1, 65, 2, 0, 1);
    issue("xor",    2'b10, mk(7'b0000000, 3'b100), 64'hFF00, 64'h0FF0, 64'hF0F0, 0, 1);
    issue("or",     2'b10, mk(7'b0000000, 3'b110), 64'hFF00, 64'h0FF0, 64'hFFF0, 0, 1);
    issue("and",    2'b10, mk(7'b0000000, 3'b111), 64'hFF00, 64'h0FF0, 64'h0F00, 0, 1);

    // Illegal decodes
    issue("ill_f7",  2'b10, mk(7'b0000010, 3'b000), 3, 4, 0, 1, 1);
    issue("ill_alt", 2'b10, mk(7'b0100000, 3'b001), 3, 4, 0, 1, 1);

    // MUL with output stall
    out_ready = 1'b0;
    issue("mul", 2'b10, mk(7'b0000001, 3'b000), 3, -64'sd2, md(-64'sd6), !MD, LM);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall result", result, md(-64'sd6));
      check("stall out_valid", out_valid, 1);
      check("stall in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall release", out_valid, 0);

    // Divide corner cases and ordinary signed/unsigned division
    issue("div_min", 2'b10, mk(7'b0000001, 3'b100), MIN, ONES, md(MIN), !MD, LM);
    issue("divu_z",  2'b10, mk(7'b0000001, 3'b101), 9, 0, md(ONES), !MD, LM);
    issue("rem_z",   2'b10, mk(7'b0000001, 3'b110), 9, 0, md(9), !MD, LM);
    issue("div_neg", 2'b10, mk(7'b0000001, 3'b100), -64'sd7, 2, md(-64'sd3), !MD, LM);
    issue("rem_neg", 2'b10, mk(7'b0000001, 3'b110), -64'sd7, 2, md(ONES), !MD, LM);
    issue("divu",    2'b10, mk(7'b0000001, 3'b101), 100, 7, md(14), !MD, LM);
    issue("remu",    2'b10, mk(7'b0000001, 3'b111), 100, 7, md(2), !MD, LM);

    // Back-to-back ADD then AND with out_ready held high
    exp_q.push_back('{res: 5, ill: 1'b0});
    exp_q.push_back('{res: 64'h30, ill: 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b1; alu_op = 2'b00; instruction = '0; op_a = 2; op_b = 3;
    @(negedge clk);
    check("b2b in_ready0", in_ready, 1);
    @(posedge clk); #1;
    alu_op = 2'b10; instruction = mk(7'b0000000, 3'b111); op_a = 64'hF0; op_b = 64'h3C;
    @(negedge clk);
    check("b2b in_ready1", in_ready, 1);
    compare_out("b2b add");
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    compare_out("b2b and");
    @(negedge clk);
    check("b2b drain", out_valid, 0);

    // Nonzero result so the reset clearing below is visible
    issue("pre_rst", 2'b00, '0, 40, 2, 42, 0, 1);

    // Reset ten cycles into a DIV
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; alu_op = 2'b10; instruction = mk(7'b0000001, 3'b100);
    op_a = 100; op_b = 7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst out_valid", out_valid, 0);
    check("mid_rst result", result, 0);
    check("mid_rst zero", zero, 0);
    check("mid_rst illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst in_ready", in_ready, 1);
    hits = 0;
    for (int i = 0; i < XLEN + 5; i++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    check("mid_rst no output", hits, 0);
    check("mid_rst queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
